datapath_seq: RTL and testbench

Parametrised, clocked successor to the single-state combinational instruction datapath. Accepts one 32-bit instruction word through a valid/ready handshake and sequences it through decode, register read, execute and writeback. Drives the integer register file and the combinational ALU with registered control and data. Supports LIMM16, CP, the ALU group and CPDR, and flags illegal opcodes.

---
 rtl/datapath_seq_if.sv | 38 +++
 rtl/datapath_seq.sv | 158 +++++++++++++++
 tb/tb_datapath_seq.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_seq_if.sv
// Instruction, register-file, ALU and debug signals for datapath_seq, bundled as one interface.
// The slave modport is the datapath; the master modport is the environment that feeds it.
interface datapath_seq_if #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 6,
    parameter int ALU_OP_W = 4
);
    logic                instr_valid;
    logic                instr_ready;
    logic [31:0]         instr;
    logic [REG_AW-1:0]   ireg_r0;
    logic [REG_AW-1:0]   ireg_r1;
    logic [DATA_W-1:0]   ireg_d0;
    logic [DATA_W-1:0]   ireg_d1;
    logic [REG_AW-1:0]   ireg_rw;
    logic [DATA_W-1:0]   ireg_dw;
    logic                ireg_we;
    logic [DATA_W-1:0]   alu_d0;
    logic [DATA_W-1:0]   alu_d1;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   alu_dout;
    logic                done;
    logic                illegal;
    logic [DATA_W-1:0]   dbg_data;
    logic                dbg_valid;

    modport slave (
        input  instr_valid, instr, ireg_d0, ireg_d1, alu_dout,
        output instr_ready, ireg_r0, ireg_r1, ireg_rw, ireg_dw, ireg_we,
               alu_d0, alu_d1, alu_op, done, illegal, dbg_data, dbg_valid
    );

    modport master (
        output instr_valid, instr, ireg_d0, ireg_d1, alu_dout,
        input  instr_ready, ireg_r0, ireg_r1, ireg_rw, ireg_dw, ireg_we,
               alu_d0, alu_d1, alu_op, done, illegal, dbg_data, dbg_valid
    );
endinterface

// File: rtl/datapath_seq.sv
// Sequential instruction datapath: IDLE -> DEC -> EXE -> WB, one instruction per 4 cycles.
// Optional CPDR debug capture enabled by defining DATAPATH_CPDR_DBG_EN (otherwise 0xD3 is illegal).
module datapath_seq #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 6,
    parameter int ALU_OP_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    datapath_seq_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DEC  = 2'd1;
    localparam logic [1:0] S_EXE  = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    logic [1:0]          state_q,  state_d;
    logic [31:0]         instr_q,  instr_d;
    logic [REG_AW-1:0]   r0_q,     r0_d;
    logic [REG_AW-1:0]   r1_q,     r1_d;
    logic [DATA_W-1:0]   alu_d0_q, alu_d0_d;
    logic [DATA_W-1:0]   alu_d1_q, alu_d1_d;
    logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   result_q, result_d;

    logic [7:0]          op;
    logic [REG_AW-1:0]   opd0, opd1, opd2;
    logic                is_limm, is_cp, is_cpdr, is_alu, is_legal;
    logic                in_wb, wr_en;

    assign op   = instr_q[31:24];
    assign opd0 = instr_q[18 +: REG_AW];
    assign opd1 = instr_q[12 +: REG_AW];
    assign opd2 = instr_q[6  +: REG_AW];

    always_comb begin
        is_limm = (op == 8'h02);
        is_cp   = (op == 8'hD2);
`ifdef DATAPATH_CPDR_DBG_EN
        is_cpdr = (op == 8'hD3);
`else
        is_cpdr = 1'b0;
`endif
        case (op)
            8'h10, 8'h11, 8'h12, 8'h14, 8'h15, 8'h18, 8'h19: is_alu = 1'b1;
            default:                                         is_alu = 1'b0;
        endcase
        is_legal = is_limm | is_cp | is_cpdr | is_alu;
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        r0_d     = r0_q;
        r1_d     = r1_q;
        alu_d0_d = alu_d0_q;
        alu_d1_d = alu_d1_q;
        alu_op_d = alu_op_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                if (!is_legal) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_EXE;
                    // Read addresses are presented during EXE, when the register file answers.
                    r0_d = (is_alu | is_cp | is_cpdr) ? opd1 : '0;
                    r1_d = is_alu ? opd2 : '0;
                end
            end
            S_EXE: begin
                state_d = S_WB;
                r0_d    = '0;
                r1_d    = '0;
                if (is_alu) begin
                    alu_d0_d = bus.ireg_d0;
                    alu_d1_d = bus.ireg_d1;
                    alu_op_d = op[ALU_OP_W-1:0];
                end
                if (is_cp | is_cpdr) result_d = bus.ireg_d0;
                if (is_limm)         result_d = DATA_W'($signed(instr_q[15:0]));
            end
            default: begin
                state_d  = S_IDLE;
                alu_d0_d = '0;
                alu_d1_d = '0;
                alu_op_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            r0_q     <= '0;
            r1_q     <= '0;
            alu_d0_q <= '0;
            alu_d1_q <= '0;
            alu_op_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            r0_q     <= r0_d;
            r1_q     <= r1_d;
            alu_d0_q <= alu_d0_d;
            alu_d1_q <= alu_d1_d;
            alu_op_q <= alu_op_d;
            result_q <= result_d;
        end
    end

    // Write strobes derive from the state register, so reset clears them immediately.
    assign in_wb = (state_q == S_WB);
    assign wr_en = in_wb & ~is_cpdr;

    assign bus.instr_ready = (state_q == S_IDLE);
    assign bus.ireg_r0     = r0_q;
    assign bus.ireg_r1     = r1_q;
    assign bus.ireg_we     = wr_en;
    assign bus.ireg_rw     = wr_en ? opd0 : '0;
    assign bus.ireg_dw     = wr_en ? (is_alu ? bus.alu_dout : result_q) : '0;
    assign bus.alu_d0      = alu_d0_q;
    assign bus.alu_d1      = alu_d1_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.illegal     = (state_q == S_DEC) & ~is_legal;
    assign bus.done        = in_wb | bus.illegal;

`ifdef DATAPATH_CPDR_DBG_EN
    logic [DATA_W-1:0] dbg_q, dbg_d;
    logic              dbg_cap;

    assign dbg_cap = in_wb & is_cpdr;

    always_comb begin
        dbg_d = dbg_q;
        if (dbg_cap) dbg_d = result_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) dbg_q <= '0;
        else       dbg_q <= dbg_d;
    end

    assign bus.dbg_valid = dbg_cap;
    assign bus.dbg_data  = dbg_cap ? result_q : dbg_q;
`else
    assign bus.dbg_valid = 1'b0;
    assign bus.dbg_data  = '0;
`endif
endmodule

// File: tb/tb_datapath_seq.sv
// Bench for datapath_seq: directed vector table, multi-cycle corner sequences and a random
// instruction stream checked against an instruction-level register-file model.
module tb_datapath_seq;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    datapath_seq_if #(.DATA_W(32), .REG_AW(6), .ALU_OP_W(4)) bus ();

    datapath_seq #(.DATA_W(32), .REG_AW(6), .ALU_OP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Environment: register file with combinational reads and an external ALU.
    logic [31:0] rf     [64] = '{default: 32'h0};
    logic [31:0] exp_rf [64] = '{default: 32'h0};

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a ^ b;
            4'h4:    return a + b;
            4'h5:    return a - b;
            4'h8:    return a << b[4:0];
            4'h9:    return a >> b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    assign bus.ireg_d0  = rf[bus.ireg_r0];
    assign bus.ireg_d1  = rf[bus.ireg_r1];
    assign bus.alu_dout = alu_fn(bus.alu_op, bus.alu_d0, bus.alu_d1);

    always @(posedge clk) if (bus.ireg_we) rf[bus.ireg_rw] <= bus.ireg_dw;

    function automatic bit op_alu(input logic [7:0] op);
        return op inside {8'h10, 8'h11, 8'h12, 8'h14, 8'h15, 8'h18, 8'h19};
    endfunction

    function automatic bit op_legal(input logic [7:0] op);
`ifdef DATAPATH_CPDR_DBG_EN
        return op_alu(op) || op == 8'h02 || op == 8'hD2 || op == 8'hD3;
`else
        return op_alu(op) || op == 8'h02 || op == 8'hD2;
`endif
    endfunction

    function automatic logic [31:0] mk_r(input logic [7:0] op, input logic [5:0] d, input logic [5:0] s1, input logic [5:0] s2);
        return {op, d, s1, s2, 6'h0};
    endfunction

    function automatic logic [31:0] mk_li(input logic [5:0] d, input logic [15:0] imm);
        return {8'h02, d, 2'b00, imm};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       nm;
        logic [31:0] w;
        bit          ill;
        bit          we;
        logic [5:0]  rw;
        logic [31:0] dw;
        bit          dbg;
        logic [31:0] dbgd;
        bit          alu;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    function automatic vec_t mkv(input string nm, input logic [31:0] w, input bit ill, input bit we,
                                 input logic [5:0] rw, input logic [31:0] dw, input bit dbg,
                                 input logic [31:0] dbgd, input bit alu, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        v.nm = nm; v.w = w; v.ill = ill; v.we = we; v.rw = rw; v.dw = dw;
        v.dbg = dbg; v.dbgd = dbgd; v.alu = alu; v.op = op; v.a = a; v.b = b;
        return v;
    endfunction

    // Issues one instruction and watches cycles N+1..N+5 after the transfer edge N.
    task automatic exec(input vec_t v);
        int we_cnt = 0, done_cnt = 0, ill_cnt = 0, dbg_cnt = 0;
        int we_k = 0, done_k = 0;
        logic [5:0]  rw_s = '0;
        logic [31:0] dw_s = '0, dbg_s = '0;
        int rdy_k = v.ill ? 2 : 4;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = v.w;
        chk({v.nm, ".rdy_idle"}, bus.instr_ready, 1);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr       = 32'h0;
        for (int k = 1; k <= 5; k++) begin
            if (bus.ireg_we)   begin we_cnt++; we_k = k; rw_s = bus.ireg_rw; dw_s = bus.ireg_dw; end
            if (bus.done)      begin done_cnt++; done_k = k; end
            if (bus.illegal)   ill_cnt++;
            if (bus.dbg_valid) begin dbg_cnt++; dbg_s = bus.dbg_data; end
            if (k == 1) chk({v.nm, ".rdy_busy"}, bus.instr_ready, 0);
            if (k == rdy_k) chk({v.nm, ".rdy_back"}, bus.instr_ready, 1);
            if (k == 3 && v.alu) begin
                chk({v.nm, ".alu_op"}, bus.alu_op, v.op);
                chk({v.nm, ".alu_d0"}, bus.alu_d0, v.a);
                chk({v.nm, ".alu_d1"}, bus.alu_d1, v.b);
            end
            if (k == 4) chk({v.nm, ".alu_clr"}, {bus.alu_d0, bus.alu_d1, 28'h0, bus.alu_op}, 64'h0);
            if (k < 5) @(negedge clk);
        end
        chk({v.nm, ".we_cnt"}, we_cnt, v.we ? 1 : 0);
        if (v.we) begin
            chk({v.nm, ".we_cyc"}, we_k, 3);
            chk({v.nm, ".rw"}, rw_s, v.rw);
            chk({v.nm, ".dw"}, dw_s, v.dw);
        end
        chk({v.nm, ".done_cnt"}, done_cnt, 1);
        chk({v.nm, ".done_cyc"}, done_k, v.ill ? 1 : 3);
        chk({v.nm, ".ill_cnt"}, ill_cnt, v.ill ? 1 : 0);
        chk({v.nm, ".dbg_cnt"}, dbg_cnt, v.dbg ? 1 : 0);
        if (v.dbg) chk({v.nm, ".dbg_data"}, dbg_s, v.dbgd);
        if (v.we) exp_rf[v.rw] = v.dw;
    endtask

    // Instruction-level reference: what the word should do given the modelled register file.
    function automatic vec_t model(input string nm, input logic [31:0] w);
        logic [7:0]  op = w[31:24];
        logic [5:0]  d = w[23:18], s1 = w[17:12], s2 = w[11:6];
        logic [15:0] imm = w[15:0];
        vec_t v = mkv(nm, w, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (!op_legal(op)) v.ill = 1;
        else if (op == 8'h02) begin v.we = 1; v.rw = d; v.dw = {{16{imm[15]}}, imm}; end
        else if (op == 8'hD2) begin v.we = 1; v.rw = d; v.dw = exp_rf[s1]; end
        else if (op == 8'hD3) begin v.dbg = 1; v.dbgd = exp_rf[s1]; end
        else begin
            v.we = 1; v.rw = d; v.alu = 1; v.op = op[3:0];
            v.a = exp_rf[s1]; v.b = exp_rf[s2];
            v.dw = alu_fn(op[3:0], v.a, v.b);
        end
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int acc;
        logic [7:0] rop;
        logic [31:0] rw_word;
        int bad_regs;
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = 32'h0;

        tbl.push_back(mkv("li_r1",  mk_li(1, 16'h0007), 0, 1, 1, 32'h7,        0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("li_r2",  mk_li(2, 16'h0005), 0, 1, 2, 32'h5,        0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("li_neg", mk_li(3, 16'h8001), 0, 1, 3, 32'hFFFF8001, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("add",    mk_r(8'h14, 4, 1, 2), 0, 1, 4, 32'd12,     0, 0, 1, 4, 32'd7, 32'd5));
        tbl.push_back(mkv("sub",    mk_r(8'h15, 6, 4, 1), 0, 1, 6, 32'd5,      0, 0, 1, 5, 32'd12, 32'd7));
        tbl.push_back(mkv("cp",     mk_r(8'hD2, 9, 4, 0), 0, 1, 9, 32'd12,     0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("ill7f",  mk_r(8'h7F, 1, 2, 3), 1, 0, 0, 0,          0, 0, 0, 0, 0, 0));
`ifdef DATAPATH_CPDR_DBG_EN
        tbl.push_back(mkv("cpdr",   mk_r(8'hD3, 0, 9, 0), 0, 0, 0, 0,          1, 32'd12, 0, 0, 0, 0));
`else
        tbl.push_back(mkv("cpdr",   mk_r(8'hD3, 0, 9, 0), 1, 0, 0, 0,          0, 0, 0, 0, 0, 0));
`endif
        tbl.push_back(mkv("li_r0",  mk_li(0, 16'h1234), 0, 1, 0, 32'h1234,     0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("xor",    mk_r(8'h12, 7, 3, 1), 0, 1, 7, 32'hFFFF8006, 0, 0, 1, 2, 32'hFFFF8001, 32'h7));

        repeat (3) @(negedge clk);
        chk("rst.ready", bus.instr_ready, 1);
        chk("rst.outs", {bus.ireg_we, bus.done, bus.illegal, bus.dbg_valid, bus.ireg_rw, bus.ireg_r0, bus.ireg_r1}, 0);
        chk("rst.data", {bus.ireg_dw, bus.alu_d0}, 0);
        chk("rst.data2", {bus.alu_d1, bus.dbg_data}, 0);
        chk("rst.aluop", bus.alu_op, 0);
        reset = 1'b0;

        foreach (tbl[i]) exec(tbl[i]);

        // instr_valid held high: the next word must wait until the block is idle again.
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = mk_r(8'hD2, 10, 4, 0);
        @(negedge clk);
        bus.instr = mk_r(8'h14, 11, 10, 1);
        acc = 0;
        for (int k = 1; k <= 6; k++) begin
            if (bus.instr_ready) begin acc = k; break; end
            @(negedge clk);
        end
        chk("hold.accept_cyc", acc, 4);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr = 32'h0;
        repeat (5) @(negedge clk);
        exp_rf[10] = exp_rf[4];
        exp_rf[11] = exp_rf[10] + exp_rf[1];
        chk("hold.r10", rf[10], exp_rf[10]);
        chk("hold.r11", rf[11], exp_rf[11]);

        // Reset during WB of LIMM16 r5 must cancel the write.
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = mk_li(5, 16'h55AA);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr = 32'h0;
        repeat (2) @(negedge clk);
        chk("rstwb.we_before", bus.ireg_we, 1);
        #2 reset = 1'b1;
        #1;
        chk("rstwb.we", bus.ireg_we, 0);
        chk("rstwb.ready", bus.instr_ready, 1);
        chk("rstwb.done", bus.done, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rstwb.r5", rf[5], exp_rf[5]);

        // Random instruction stream against the model.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 5))
                0: rw_word = mk_li(6'($urandom), 16'($urandom));
                1: rw_word = mk_r(8'hD2, 6'($urandom), 6'($urandom), 6'($urandom));
                2, 3: begin
                    case ($urandom_range(0, 6))
                        0: rop = 8'h10; 1: rop = 8'h11; 2: rop = 8'h12; 3: rop = 8'h14;
                        4: rop = 8'h15; 5: rop = 8'h18; default: rop = 8'h19;
                    endcase
                    rw_word = mk_r(rop, 6'($urandom), 6'($urandom), 6'($urandom));
                end
                4: begin
                    rop = 8'($urandom);
                    while (op_legal(rop) || rop == 8'hD3) rop = 8'($urandom);
                    rw_word = {rop, 24'($urandom)};
                end
                default: rw_word = mk_r(8'hD3, 6'($urandom), 6'($urandom), 6'($urandom));
            endcase
            exec(model($sformatf("rnd%0d", n), rw_word));
        end

        bad_regs = 0;
        for (int r = 0; r < 64; r++) if (rf[r] !== exp_rf[r]) bad_regs++;
        chk("final.regfile_mismatches", bad_regs, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
